program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, default 16, instruction address width.
REQ-002 Parameter OFF_W, default 8, signed relative-branch offset width, SHALL satisfy OFF_W <= ADDR_W.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries, SHALL be >= 2.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset; the port keeps the codebase name "reset" and asserts at 0.
REQ-006 halt  input  1  request freeze; latched until resume.
REQ-007 resume  input  1  leave HALTED state.
REQ-008 stall  input  1  hold PC for this cycle only (pipeline back-pressure).
REQ-009 bnz  input  1  absolute jump to jump_here.
REQ-010 br_rel  input  1  relative branch by offset.
REQ-011 call  input  1  push return address, jump to jump_here.
REQ-012 ret  input  1  pop return address and jump to it.
REQ-013 jump_here  input  ADDR_W  absolute target.
REQ-014 offset  input  OFF_W  signed two's-complement displacement.
REQ-015 addr_out  output  ADDR_W  current fetch address (registered).
REQ-016 halted  output  1  high in HALTED state.
REQ-017 ras_full / ras_empty  output  1 each  stack occupancy flags.
REQ-018 ras_err  output  1  sticky overflow/underflow flag.

Function
REQ-019 FSM states RUN and HALTED; RUN->HALTED when halt=1 in RUN; HALTED->RUN when resume=1 and halt=0; halt wins when both high.
REQ-020 In HALTED, and in RUN with stall=1, addr_out, stack and flags SHALL hold; control inputs that cycle SHALL be ignored.
REQ-021 The cycle that transitions RUN->HALTED SHALL NOT advance addr_out.
REQ-022 In RUN without stall, next addr_out by priority: ret > call > bnz > br_rel > addr_out+1; lower-priority requests that cycle are dropped.
REQ-023 br_rel: next = addr_out + sign_extend(offset), modulo 2^ADDR_W.
REQ-024 Increment SHALL wrap from 2^ADDR_W-1 to 0.
REQ-025 call: push (addr_out+1) mod 2^ADDR_W, next = jump_here; pushed value visible to a ret in the immediately following cycle.
REQ-026 call with ras_full: no push, jump still taken, ras_err set.
REQ-027 ret with entries: next = top entry, pop; one-cycle latency from ret to new addr_out.
REQ-028 ret with ras_empty: no pop, next = addr_out+1, ras_err set.
REQ-029 ras_full = (count == RAS_DEPTH); ras_empty = (count == 0); both derived combinationally from the registered count.
REQ-030 ras_err SHALL clear only on reset.

Reset
REQ-031 While reset=0: addr_out=0, state=RUN, halted=0, stack count=0, ras_empty=1, ras_full=0, ras_err=0, asynchronously, independent of clk.
REQ-032 Reset asserted mid-operation (including HALTED or full stack) SHALL discard all stack contents; first post-reset advance yields addr_out=1.
REQ-033 Stack storage data need not be reset; only count/pointer are.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (RUN, HALTED) and the next-PC source enum (INC, JMP, REL, CALL, RET, HOLD).
REQ-035 The return-address stack SHALL be a separate sub-module ras_stack (params ADDR_W, RAS_DEPTH; push, pop, data_in, top, full, empty).
REQ-036 addr_out, state, count and ras_err SHALL be flip-flops; no combinational path from inputs to addr_out.

Verification
REQ-037 Release reset, no controls, 5 cycles -> addr_out 1,2,3,4,5.
REQ-038 ADDR_W=16, addr_out=0x0010, br_rel offset=8'hF0 -> addr_out=0x0000; at 0xFFFF no control -> 0x0000.
REQ-039 At 0x0020 call jump_here=0x0100; next cycle ret -> addr_out 0x0100 then 0x0021, ras_empty=1, ras_err=0.
REQ-040 RAS_DEPTH=4: five nested calls -> fifth jumps, ras_full=1, ras_err=1; five rets -> four correct returns, fifth gives addr_out+1.
REQ-041 halt at addr 0x0005 -> addr_out holds 0x0005, halted=1 for 10 cycles despite bnz; resume -> 0x0006 next cycle; stall one cycle -> one-cycle hold.
REQ-042 ret and call and bnz same cycle with one entry 0x0040 -> addr_out=0x0040, no push; reset pulse asynchronous mid-cycle -> addr_out=0 immediately, ras_empty=1.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg: FSM state and next-PC source encodings shared by the sequencer.
package program_sequencer_pkg;
  typedef enum logic {RUN, HALTED} state_t;
  typedef enum logic [2:0] {INC, JMP, REL, CALL, RET, HOLD} src_t;
endpackage

// File: rtl/program_sequencer_ras_stack.sv
// ras_stack: return-address LIFO; only the occupancy count is reset, storage is not.
module ras_stack #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] data_in,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int IW = $clog2(RAS_DEPTH);
  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [CW-1:0] count, top_idx;
  assign top_idx = count - CW'(1);
  assign top     = mem[top_idx[IW-1:0]];
  assign full    = count == CW'(RAS_DEPTH);
  assign empty   = count == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else count <= (push && !full) ? count + CW'(1) : (pop && !empty) ? count - CW'(1) : count;
  always_ff @(posedge clk)
    if (push && !full) mem[count[IW-1:0]] <= data_in;
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: fetch-address generator with halt/stall control, branches and a return-address stack.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int OFF_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              resume,
  input  logic              stall,
  input  logic              bnz,
  input  logic              br_rel,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jump_here,
  input  logic [OFF_W-1:0]  offset,
  output logic [ADDR_W-1:0] addr_out,
  output logic              halted,
  output logic              ras_full,
  output logic              ras_empty,
  output logic              ras_err
);
  state_t state, next_state;
  src_t src;
  logic push, pop, err_set;
  logic [ADDR_W-1:0] inc, rel, top, next_addr;
  assign inc    = addr_out + ADDR_W'(1);
  assign rel    = addr_out + ADDR_W'($signed(offset));
  assign halted = state == HALTED;
  ras_stack #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(inc),
    .top(top), .full(ras_full), .empty(ras_empty)
  );
  always_comb begin
    next_state = state;
    src        = HOLD;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    if (state == HALTED) next_state = (resume && !halt) ? RUN : HALTED;
    else if (halt) next_state = HALTED;
    else if (!stall) begin
      // ret on an empty stack falls through to a plain increment
      if (ret) begin
        src     = ras_empty ? INC : RET;
        pop     = !ras_empty;
        err_set = ras_empty;
      end else if (call) begin
        src     = CALL;
        push    = !ras_full;
        err_set = ras_full;
      end else src = bnz ? JMP : br_rel ? REL : INC;
    end
    next_addr = src == RET ? top :
                (src == CALL || src == JMP) ? jump_here :
                src == REL ? rel :
                src == INC ? inc : addr_out;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= RUN;
      addr_out <= '0;
      ras_err  <= 1'b0;
    end else begin
      state    <= next_state;
      addr_out <= next_addr;
      ras_err  <= ras_err | err_set;
    end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed and random steps checked against a queue-based reference model.
module tb_program_sequencer;
  localparam int H = 64, RS = 32, ST = 16, RT = 8, CL = 4, BN = 2, BR = 1;
  logic clk = 1'b0, reset = 1'b0;
  logic halt = 0, resume = 0, stall = 0, bnz = 0, br_rel = 0, call = 0, ret = 0;
  logic [15:0] jump_here = '0;
  logic [7:0] offset = '0;
  logic [15:0] addr_out;
  logic halted, ras_full, ras_empty, ras_err;
  int total = 0, passed = 0;
  logic [15:0] m_pc;
  bit m_halt, m_err;
  logic [15:0] m_ras[$];

  program_sequencer dut (
    .clk(clk), .reset(reset), .halt(halt), .resume(resume), .stall(stall), .bnz(bnz),
    .br_rel(br_rel), .call(call), .ret(ret), .jump_here(jump_here), .offset(offset),
    .addr_out(addr_out), .halted(halted), .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".addr"}, 32'(addr_out), 32'(m_pc));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
    chk({tag, ".full"}, 32'(ras_full), 32'(m_ras.size() == 4));
    chk({tag, ".empty"}, 32'(ras_empty), 32'(m_ras.size() == 0));
    chk({tag, ".err"}, 32'(ras_err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_pc = '0; m_halt = 0; m_err = 0; m_ras.delete();
  endtask

  task automatic step(input string tag, input logic [6:0] c, input logic [15:0] jh = '0, input logic [7:0] off = '0);
    {halt, resume, stall, ret, call, bnz, br_rel} = c;
    jump_here = jh; offset = off;
    @(posedge clk);
    if (m_halt) m_halt = !(resume && !halt);
    else if (halt) m_halt = 1;
    else if (!stall) begin
      if (ret) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin m_pc = m_pc + 16'd1; m_err = 1; end
      end else if (call) begin
        if (m_ras.size() < 4) m_ras.push_back(m_pc + 16'd1);
        else m_err = 1;
        m_pc = jh;
      end else if (bnz) m_pc = jh;
      else if (br_rel) m_pc = m_pc + {{8{off[7]}}, off};
      else m_pc = m_pc + 16'd1;
    end
    #1 chk_all(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1 chk_all(tag);
    #1 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 chk_all("reset");
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) step("count", 0);
    step("bnz10", BN, 16'h0010);
    step("rel_neg", BR, 16'h0, 8'hF0);
    step("bnzffff", BN, 16'hFFFF);
    step("wrap", 0);
    step("bnz20", BN, 16'h0020);
    step("call", CL, 16'h0100);
    step("ret", RT);
    for (int i = 0; i < 5; i++) step("nest_call", CL, 16'h0200 + 16'(i * 16));
    for (int i = 0; i < 5; i++) step("nest_ret", RT);
    step("bnz5", BN, 16'h0005);
    step("halt", H);
    for (int i = 0; i < 10; i++) step("halted_bnz", BN, 16'h0777);
    step("resume", RS);
    step("after_resume", 0);
    step("stall", ST);
    step("after_stall", 0);
    step("bnz3f", BN, 16'h003F);
    step("call40", CL, 16'h0080);
    step("ret_call_bnz", RT | CL | BN, 16'h0999);
    step("call_full", CL, 16'h0300);
    step("halt_full", H);
    async_reset_pulse("async_reset");
    step("post_reset", 0);
    for (int i = 0; i < 400; i++) begin
      logic [6:0] c;
      c = 7'($urandom) & 7'b0001111;
      if ($urandom_range(15) == 0) c |= 7'(H);
      if ($urandom_range(3) == 0) c |= 7'(RS);
      if ($urandom_range(7) == 0) c |= 7'(ST);
      step("rand", c, 16'($urandom), 8'($urandom));
      if (i == 200) begin
        async_reset_pulse("rand_reset");
        step("rand_post_reset", 0);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
